// File: rtl/wb_sdram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_sdram_port_arb
// Purpose  : Arbitrates WB_PORTS 32-bit Wishbone slaves onto the 16-bit SDRAM
//            access interface, splitting each access into two big-endian
//            halfword beats. SDRAM_ARB_FIXED_PRIO_EN selects fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module wb_sdram_port_arb #(
    parameter int WB_PORTS  = 3,
    parameter int ADR_WIDTH = 32
) (
    input  logic                    sdram_clk,
    input  logic                    sdram_rst,
    input  logic [WB_PORTS*32-1:0]  wb_adr_i,
    input  logic [WB_PORTS-1:0]     wb_stb_i,
    input  logic [WB_PORTS-1:0]     wb_cyc_i,
    input  logic [WB_PORTS-1:0]     wb_we_i,
    input  logic [WB_PORTS*4-1:0]   wb_sel_i,
    input  logic [WB_PORTS*32-1:0]  wb_dat_i,
    output logic [WB_PORTS*32-1:0]  wb_dat_o,
    output logic [WB_PORTS-1:0]     wb_ack_o,
    input  logic                    sdram_if_idle_i,
    output logic [ADR_WIDTH-1:0]    sdram_if_adr_o,
    output logic [15:0]             sdram_if_dat_o,
    input  logic [15:0]             sdram_if_dat_i,
    output logic [1:0]              sdram_if_sel_o,
    output logic                    sdram_if_acc_o,
    output logic                    sdram_if_we_o,
    input  logic                    sdram_if_ack_i,
    output logic [WB_PORTS-1:0]     grant_o
);

    localparam int PW = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_ACK} state_t;

    state_t                 state_q, state_d;
    logic [29:0]            adr_q;
    logic                   we_q;
    logic [3:0]             sel_q;
    logic [31:0]            dat_q;
    logic [15:0]            hi_q;
    logic [31:0]            word_q;
    logic [WB_PORTS-1:0]    grant_q;

    logic [WB_PORTS-1:0]    w_req;
    logic                   w_any;
    logic [PW-1:0]          w_win;
    logic [31:0]            w_hw_adr;

    assign w_req = wb_cyc_i & wb_stb_i;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = WB_PORTS - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_any = 1'b1;
                w_win = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          port_q;

    // Search starts one past the last granted port and wraps.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < WB_PORTS; i++) begin
            if (!w_any && w_req[(int'(ptr_q) + 1 + i) % WB_PORTS]) begin
                w_any = 1'b1;
                w_win = PW'((int'(ptr_q) + 1 + i) % WB_PORTS);
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            ptr_q  <= '0;
            port_q <= '0;
        end else if (state_q == S_IDLE && w_any && sdram_if_idle_i) begin
            port_q <= w_win;
        end else if (state_q == S_ACK) begin
            ptr_q  <= port_q;
        end
    end
`endif

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        w_hw_adr       = '0;
        sdram_if_dat_o = '0;
        sdram_if_sel_o = '0;
        sdram_if_acc_o = 1'b0;
        sdram_if_we_o  = 1'b0;
        wb_ack_o       = '0;
        case (state_q)
            S_IDLE: if (w_any && sdram_if_idle_i) state_d = S_HI;
            S_HI: begin
                w_hw_adr       = {adr_q, 2'b00};
                sdram_if_dat_o = dat_q[31:16];
                sdram_if_sel_o = sel_q[3:2];
                sdram_if_acc_o = 1'b1;
                sdram_if_we_o  = we_q;
                if (sdram_if_ack_i) state_d = S_LO;
            end
            S_LO: begin
                w_hw_adr       = {adr_q, 2'b10};
                sdram_if_dat_o = dat_q[15:0];
                sdram_if_sel_o = sel_q[1:0];
                sdram_if_acc_o = 1'b1;
                sdram_if_we_o  = we_q;
                if (sdram_if_ack_i) state_d = S_ACK;
            end
            S_ACK: begin
                wb_ack_o = grant_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read word is committed only on the final beat so wb_dat_o never shows a half-updated value.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            hi_q    <= '0;
            word_q  <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (w_any && sdram_if_idle_i) begin
                    adr_q   <= wb_adr_i[int'(w_win)*32+2 +: 30];
                    we_q    <= wb_we_i[w_win];
                    sel_q   <= wb_sel_i[int'(w_win)*4 +: 4];
                    dat_q   <= wb_dat_i[int'(w_win)*32 +: 32];
                    grant_q <= WB_PORTS'(1) << w_win;
                end
                S_HI: if (sdram_if_ack_i && !we_q) hi_q <= sdram_if_dat_i;
                S_LO: if (sdram_if_ack_i && !we_q) word_q <= {hi_q, sdram_if_dat_i};
                S_ACK: grant_q <= '0;
                default: ;
            endcase
        end
    end

    assign wb_dat_o = {WB_PORTS{word_q}};
    assign grant_o  = grant_q;

    generate
        if (ADR_WIDTH == 32) begin : g_adr_eq
            assign sdram_if_adr_o = w_hw_adr;
        end else if (ADR_WIDTH > 32) begin : g_adr_ext
            assign sdram_if_adr_o = {{(ADR_WIDTH-32){1'b0}}, w_hw_adr};
        end else begin : g_adr_trunc
            assign sdram_if_adr_o = w_hw_adr[ADR_WIDTH-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_sdram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_sdram_port_arb
// Purpose  : Directed self-checking bench for wb_sdram_port_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sdram_port_arb;

    localparam int NP = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP*32-1:0]  wb_adr = '0;
    logic [NP-1:0]     wb_stb = '0;
    logic [NP-1:0]     wb_cyc = '0;
    logic [NP-1:0]     wb_we  = '0;
    logic [NP*4-1:0]   wb_sel = '0;
    logic [NP*32-1:0]  wb_wdat = '0;
    logic [NP*32-1:0]  wb_rdat;
    logic [NP-1:0]     wb_ack;
    logic              if_idle = 1'b1;
    logic [31:0]       if_adr;
    logic [15:0]       if_dat_o;
    logic [15:0]       if_dat_i = '0;
    logic [1:0]        if_sel;
    logic              if_acc;
    logic              if_we;
    logic              if_ack = 1'b0;
    logic [NP-1:0]     grant;

    int n_checks = 0;
    int n_errors = 0;

    wb_sdram_port_arb #(.WB_PORTS(NP), .ADR_WIDTH(32)) u_dut (
        .sdram_clk       (clk),
        .sdram_rst       (rst),
        .wb_adr_i        (wb_adr),
        .wb_stb_i        (wb_stb),
        .wb_cyc_i        (wb_cyc),
        .wb_we_i         (wb_we),
        .wb_sel_i        (wb_sel),
        .wb_dat_i        (wb_wdat),
        .wb_dat_o        (wb_rdat),
        .wb_ack_o        (wb_ack),
        .sdram_if_idle_i (if_idle),
        .sdram_if_adr_o  (if_adr),
        .sdram_if_dat_o  (if_dat_o),
        .sdram_if_dat_i  (if_dat_i),
        .sdram_if_sel_o  (if_sel),
        .sdram_if_acc_o  (if_acc),
        .sdram_if_we_o   (if_we),
        .sdram_if_ack_i  (if_ack),
        .grant_o         (grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit req, input bit we,
                            input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        wb_cyc[p]         = req;
        wb_stb[p]         = req;
        wb_we[p]          = we;
        wb_adr[p*32 +: 32] = adr;
        wb_wdat[p*32 +: 32] = dat;
        wb_sel[p*4 +: 4]  = sel;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_p;
        logic [31:0] base [NP];
        logic [31:0] last_word;
        base[0] = 32'h0000_3000;
        base[1] = 32'h0000_4000;
        base[2] = 32'h0000_5000;

        // Reset state
        tick(); tick();
        check("rst_acc",   64'(if_acc),  64'h0);
        check("rst_grant", 64'(grant),   64'h0);
        check("rst_ack",   64'(wb_ack),  64'h0);
        check("rst_dat",   64'(wb_rdat[31:0]), 64'h0);
        check("rst_adr",   64'(if_adr),  64'h0);
        rst = 1'b0;

        // Port0 write, two big-endian beats
        set_port(0, 1, 1, 32'h0000_1004, 32'hA1B2_C3D4, 4'hF);
        check("w_idle_acc", 64'(if_acc), 64'h0);
        tick();
        check("w_hi_acc",   64'(if_acc),   64'h1);
        check("w_hi_adr",   64'(if_adr),   64'h1004);
        check("w_hi_dat",   64'(if_dat_o), 64'hA1B2);
        check("w_hi_sel",   64'(if_sel),   64'h3);
        check("w_hi_we",    64'(if_we),    64'h1);
        check("w_hi_grant", 64'(grant),    64'h1);
        if_ack = 1'b1; tick(); if_ack = 1'b0;
        check("w_lo_acc",   64'(if_acc),   64'h1);
        check("w_lo_adr",   64'(if_adr),   64'h1006);
        check("w_lo_dat",   64'(if_dat_o), 64'hC3D4);
        check("w_lo_wback", 64'(wb_ack),   64'h0);
        if_ack = 1'b1; tick(); if_ack = 1'b0;
        check("w_ack",      64'(wb_ack),   64'h1);
        check("w_ack_acc",  64'(if_acc),   64'h0);
        tick();
        check("w_done_ack",   64'(wb_ack), 64'h0);
        check("w_done_grant", 64'(grant),  64'h0);
        set_port(0, 0, 0, '0, '0, '0);
        tick();
        check("w_no_regrant", 64'(if_acc), 64'h0);

        // Port1 read assembles 0x12345678
        set_port(1, 1, 0, 32'h0000_2000, '0, 4'hF);
        tick();
        check("r_hi_grant", 64'(grant),  64'h2);
        check("r_hi_adr",   64'(if_adr), 64'h2000);
        check("r_hi_we",    64'(if_we),  64'h0);
        if_ack = 1'b1; if_dat_i = 16'h1234; tick(); if_ack = 1'b0;
        check("r_lo_adr",   64'(if_adr), 64'h2002);
        check("r_lo_word",  64'(wb_rdat[63:32]), 64'h0);
        if_ack = 1'b1; if_dat_i = 16'h5678; tick(); if_ack = 1'b0;
        check("r_ack",      64'(wb_ack), 64'h2);
        check("r_word_p1",  64'(wb_rdat[63:32]), 64'h1234_5678);
        check("r_word_p0",  64'(wb_rdat[31:0]),  64'h1234_5678);
        tick();
        set_port(1, 0, 0, '0, '0, '0);
        check("r_hold_ack",  64'(wb_ack), 64'h0);
        check("r_hold_word", 64'(wb_rdat[95:64]), 64'h1234_5678);

        // All three ports request continuously; pointer is at port1
        for (int p = 0; p < NP; p++) set_port(p, 1, 0, base[p], '0, 4'hF);
        last_word = '0;
        for (int k = 0; k < 6; k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            exp_p = 0;
`else
            exp_p = (2 + k) % NP;
`endif
            tick();
            check($sformatf("rr%0d_grant", k), 64'(grant),  64'(1 << exp_p));
            check($sformatf("rr%0d_adr", k),   64'(if_adr), 64'(base[exp_p]));
            if_ack = 1'b1; if_dat_i = 16'h1000 + 16'(k); tick(); if_ack = 1'b0;
            check($sformatf("rr%0d_lo_adr", k), 64'(if_adr), 64'(base[exp_p] + 32'd2));
            if_ack = 1'b1; if_dat_i = 16'h2000 + 16'(k); tick(); if_ack = 1'b0;
            last_word = {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
            check($sformatf("rr%0d_wback", k), 64'(wb_ack), 64'(1 << exp_p));
            check($sformatf("rr%0d_word", k),  64'(wb_rdat[31:0]), 64'(last_word));
            tick();
            check($sformatf("rr%0d_gap", k), 64'(if_acc), 64'h0);
        end
        for (int p = 0; p < NP; p++) set_port(p, 0, 0, '0, '0, '0);

        // Idle low blocks grant; stray ack ignored; sel=0011 write at wrap address
        if_idle = 1'b0;
        set_port(2, 1, 1, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 4'h3);
        if_ack = 1'b1; tick(); if_ack = 1'b0;
        check("blk0_acc",   64'(if_acc), 64'h0);
        check("blk0_grant", 64'(grant),  64'h0);
        tick(); tick();
        check("blk2_acc",   64'(if_acc), 64'h0);
        if_idle = 1'b1;
        tick();
        check("unblk_acc",   64'(if_acc),   64'h1);
        check("unblk_grant", 64'(grant),    64'h4);
        check("sel_hi_adr",  64'(if_adr),   64'hFFFF_FFFC);
        check("sel_hi_sel",  64'(if_sel),   64'h0);
        check("sel_hi_dat",  64'(if_dat_o), 64'hDEAD);
        if_idle = 1'b0;
        if_ack = 1'b1; tick(); if_ack = 1'b0;
        check("sel_lo_adr",  64'(if_adr),   64'hFFFF_FFFE);
        check("sel_lo_sel",  64'(if_sel),   64'h3);
        check("sel_lo_dat",  64'(if_dat_o), 64'hBEEF);
        if_ack = 1'b1; tick(); if_ack = 1'b0;
        check("sel_wback",   64'(wb_ack), 64'h4);
        check("sel_word",    64'(wb_rdat[31:0]), 64'(last_word));
        if_idle = 1'b1;
        tick();
        set_port(2, 0, 0, '0, '0, '0);

        // Reset during LO aborts silently; a fresh request is then served
        set_port(0, 1, 0, 32'h0000_6000, '0, 4'hF);
        tick();
        check("ra_hi_grant", 64'(grant), 64'h1);
        if_ack = 1'b1; if_dat_i = 16'h1111; tick(); if_ack = 1'b0;
        check("ra_lo_acc",   64'(if_acc), 64'h1);
        rst = 1'b1; if_ack = 1'b1; if_dat_i = 16'h2222;
        tick();
        rst = 1'b0; if_ack = 1'b0;
        check("ra_acc",   64'(if_acc), 64'h0);
        check("ra_grant", 64'(grant),  64'h0);
        check("ra_wback", 64'(wb_ack), 64'h0);
        check("ra_word",  64'(wb_rdat[31:0]), 64'h0);
        tick();
        check("ra2_grant", 64'(grant),  64'h1);
        check("ra2_adr",   64'(if_adr), 64'h6000);
        if_ack = 1'b1; if_dat_i = 16'hCAFE; tick();
        if_dat_i = 16'hF00D; tick(); if_ack = 1'b0;
        check("ra2_wback", 64'(wb_ack), 64'h1);
        check("ra2_word",  64'(wb_rdat[95:64]), 64'hCAFE_F00D);
        tick();
        set_port(0, 0, 0, '0, '0, '0);
        check("ra2_end_ack", 64'(wb_ack), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
